// File: rtl/audio_pkg.sv
// Shared audio definitions for the pacer and its sample ring.
package audio_pkg;

  localparam int AUDIO_WIDTH     = 24;
  localparam int AUDIO_SAMPLE_HZ = 48000;

  typedef struct packed {
    logic [AUDIO_WIDTH-1:0] left;
    logic [AUDIO_WIDTH-1:0] right;
  } stereo_sample_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/audio_sample_ring.sv
// DEPTH x DW circular buffer with registered level; reads the head combinationally.
module audio_sample_ring
  import audio_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int DW    = 2 * AUDIO_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [DW-1:0]          push_data_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          head_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_LVL  = (AW + 1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          push_ok, pop_ok;

  // Overflowing pushes and empty pops are ignored so pointers never desync.
  assign push_ok = push_i && (level_q != FULL_LVL);
  assign pop_ok  = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + ONE_LVL;
      2'b01:   level_d = level_q - ONE_LVL;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/audio_sample_pacer.sv
// Buffers bursty stereo samples and releases one per audio period via a fractional accumulator.
// Define AUDIO_PACER_MUTE_ON_UNDERRUN_EN to output silence on underrun instead of holding.
module audio_sample_pacer
  import audio_pkg::*;
#(
  parameter int CLK_HZ    = 30000000,
  parameter int SAMPLE_HZ = AUDIO_SAMPLE_HZ,
  parameter int DEPTH     = 16,
  parameter int WIDTH     = AUDIO_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  // Upstream handshake: a sample transfers on any rising edge where in_valid && in_ready.
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_left,
  input  logic [WIDTH-1:0]       in_right,
  output logic [WIDTH-1:0]       audio_l,
  output logic [WIDTH-1:0]       audio_r,
  output logic                   sample_tick,
  output logic [$clog2(DEPTH):0] level,
  output logic [15:0]            underrun_count
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [31:0]   CLK_C    = 32'(CLK_HZ);
  localparam logic [31:0]   SAMPLE_C = 32'(SAMPLE_HZ);
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [31:0]        acc_q, acc_d, acc_sum;
  logic               tick;
  logic               push, pop;
  logic [LW-1:0]      level_w;
  logic [2*WIDTH-1:0] head_w;
  logic [WIDTH-1:0]   audio_l_q, audio_r_q;
  logic               sample_tick_q;
  logic [15:0]        underrun_q;

  // Remainder carries into the next period, so the long-run rate is exact.
  always_comb begin
    acc_sum = acc_q + SAMPLE_C;
    tick    = (acc_sum >= CLK_C);
    acc_d   = tick ? (acc_sum - CLK_C) : acc_sum;
  end

  assign in_ready = (level_w != FULL_LVL);
  assign push     = in_valid && in_ready;
  assign pop      = tick && (level_w != '0);

  audio_sample_ring #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_ring (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i ({in_left, in_right}),
    .pop_i       (pop),
    .head_o      (head_w),
    .level_o     (level_w)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q         <= '0;
      audio_l_q     <= '0;
      audio_r_q     <= '0;
      sample_tick_q <= 1'b0;
      underrun_q    <= '0;
    end else begin
      acc_q         <= acc_d;
      sample_tick_q <= tick;
      if (pop) begin
        audio_l_q <= head_w[2*WIDTH-1:WIDTH];
        audio_r_q <= head_w[WIDTH-1:0];
      end else if (tick) begin
        underrun_q <= sat_inc16(underrun_q);
`ifdef AUDIO_PACER_MUTE_ON_UNDERRUN_EN
        audio_l_q <= '0;
        audio_r_q <= '0;
`else
        audio_l_q <= audio_l_q;
        audio_r_q <= audio_r_q;
`endif
      end
    end
  end

  assign audio_l        = audio_l_q;
  assign audio_r        = audio_r_q;
  assign sample_tick    = sample_tick_q;
  assign level          = level_w;
  assign underrun_count = underrun_q;

endmodule

// File: doc/audio_sample_pacer.md
Name: audio_sample_pacer

Overview:
Stereo audio pacing stage directly upstream of the HDMI display block's audioL/audioR inputs.
- Accepts 24-bit stereo samples from the synth/mixer logic through a valid/ready handshake, at bursty or arbitrary times.
- Buffers them in a small FIFO.
- Releases exactly one sample per audio period, using a drift-free fractional rate accumulator.
- Holds audio_l/audio_r stable between updates so the 48 kHz HDMI audio sampler always captures a settled word.

Parameters:
CLK_HZ, 30000000, frequency of clock in Hz
SAMPLE_HZ, 48000, output sample rate in Hz; must satisfy SAMPLE_HZ < CLK_HZ
DEPTH, 16, FIFO depth in stereo samples; power of two, at least 2
WIDTH, 24, bits per channel

Ports:
clock  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream sample valid
in_ready  output  1  FIFO can accept a sample this cycle
in_left  input  WIDTH  left sample, two's complement
in_right  input  WIDTH  right sample, two's complement
audio_l  output  WIDTH  held left output; feeds display audioL
audio_r  output  WIDTH  held right output; feeds display audioR
sample_tick  output  1  one-cycle pulse in the first cycle that new audio_l/audio_r are visible
level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
underrun_count  output  16  saturating count of ticks that found the FIFO empty

Behaviour:
- One clock domain. Reset is synchronous and active-high; the clock and reset ports are named clock and reset.
- Reset values:
  - audio_l = 0, audio_r = 0, sample_tick = 0.
  - level = 0, underrun_count = 0.
  - Accumulator = 0; FIFO pointers = 0.
  - in_ready = 1 in the first cycle after reset deasserts.
- Reset asserted mid-operation discards all buffered samples immediately. Outputs return to their reset values on the next edge.
- Rate accumulator (32-bit, unsigned), evaluated every cycle:
  - If acc + SAMPLE_HZ >= CLK_HZ: acc <= acc + SAMPLE_HZ - CLK_HZ and internal tick = 1.
  - Otherwise: acc <= acc + SAMPLE_HZ and tick = 0.
  - With the defaults, tick fires every 625 cycles exactly. The first tick occurs on the 625th clock after reset deasserts.
- Push: occurs when in_valid && in_ready.
  - in_ready = (level != DEPTH) and is derived from the registered level only.
  - When the FIFO is full, a pop in the same cycle does not raise in_ready that cycle.
- Pop: occurs on an internal tick when level != 0. The head sample is registered into audio_l/audio_r, and sample_tick is asserted on the following cycle together with the new values.
- Underrun: an internal tick with level == 0.
  - Outputs keep their previous values.
  - sample_tick is still asserted on the following cycle.
  - underrun_count increments, saturating at 16'hFFFF.
- Push and tick in the same cycle:
  - level != 0: both take effect and level is unchanged.
  - level == 0: there is no bypass. The tick is an underrun, the pushed sample is stored, and level becomes 1.
- Latency: a sample pushed at edge t can appear no earlier than the first tick at edge >= t+1, and becomes visible one cycle after that tick.
- Data passes through bit-exact; no arithmetic is applied to samples.

Optional Feature:
Macro AUDIO_PACER_MUTE_ON_UNDERRUN_EN.
- Defined: an underrun tick loads audio_l = 0 and audio_r = 0 (silence) instead of holding the previous values. underrun_count and sample_tick behave as in Behaviour.
- Undefined: the previous sample is held on underrun.

Decomposition:
- Shared package audio_pkg:
  - AUDIO_WIDTH = 24.
  - AUDIO_SAMPLE_HZ = 48000.
  - typedef stereo_sample_t as a packed struct {left, right} of AUDIO_WIDTH each.
- One sub-module, audio_sample_ring: a synchronous DEPTH x 2*WIDTH circular buffer with push/pop/level. It handles pointer wrap at DEPTH-1 -> 0.
- The pacer top level holds the accumulator, output registers and underrun counter.

Test Plan:
- Reset, then idle for 1300 cycles: sample_tick pulses at cycles 626 and 1251; outputs stay 0; underrun_count = 2.
- Push L=24'h123456, R=24'hFEDCBA at cycle 10: level = 1. At cycle 626 audio_l = 24'h123456, audio_r = 24'hFEDCBA with sample_tick = 1; level = 0; underrun_count = 0.
- Burst 20 valid samples (values 1..20) starting at cycle 5: in_ready drops after 16 pushes; level = 16; samples 17..20 stall until the first pop; outputs then emit 1,2,3,... in order, one per 625 cycles.
- Push on the exact tick cycle with an empty FIFO: underrun_count increments and the outputs hold. The sample appears at the next tick, 625 cycles later.
- Run 100000 cycles at 30 MHz: exactly 160 sample_tick pulses, all spaced 625 cycles apart. With CLK_HZ = 25000000 the spacing alternates between 520 and 521 cycles; 48 ticks per 25000 cycles.
- Assert reset mid-stream with level = 5: the next cycle gives level = 0, outputs 0, and underrun_count = 0. With AUDIO_PACER_MUTE_ON_UNDERRUN_EN defined, a later underrun forces outputs to 0 after a nonzero sample.
